// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam logic [6:0]  OP_J         = 7'd2;
    localparam logic [6:0]  OP_BEQ       = 7'd4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection: sequential, branch, or jump target.
module pc_next_logic (
    input  logic [31:0] pc,
    input  logic [25:0] target,
    input  logic        pcsrc,
    input  logic        jump,
    output logic [31:0] next_pc
);

    logic [31:0] pc4;
    logic [31:0] br_off;

    assign pc4    = pc + 32'd4;
    // Branch immediate is the low 16 target bits, sign-extended and word-scaled.
    assign br_off = {{14{target[15]}}, target[15:0], 2'b00};

    always_comb begin
        next_pc = pc4;
        if (jump) begin
            next_pc = {pc4[31:28], target, 2'b00};
        end else if (pcsrc) begin
            next_pc = pc4 + br_off;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, fetches one word over req/ack, hands it to decode over valid/ready.
//  state | meaning
//  IDLE  | one cycle after reset before the first request
//  REQ   | imem_req high at pc, waiting for imem_ack
//  HOLD  | instruction held valid, waiting for instr_ready
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [31:0]      instr,
    output logic [6:0]       opcode,
    output logic [5:0]       funct,
    output logic [31:0]      pc,
    input  logic             pcsrc,
    input  logic             jump,
    output logic [CNT_W-1:0] retired_cnt
);

    fetch_state_t state, state_nxt;
    logic         capture;
    logic         accept;
    logic [31:0]  next_pc;

    assign capture = (state == REQ) && imem_ack;
    assign accept  = (state == HOLD) && instr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = REQ;
            REQ:     if (imem_ack)    state_nxt = HOLD;
            HOLD:    if (instr_ready) state_nxt = REQ;
            default: state_nxt = IDLE;
        endcase
    end

    // Decoded from state only, so imem_req falls together with the async reset.
    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state)
            REQ:     imem_req    = 1'b1;
            HOLD:    instr_valid = 1'b1;
            default: ;
        endcase
    end

    pc_next_logic u_pc_next (
        .pc      (pc),
        .target  (instr[25:0]),
        .pcsrc   (pcsrc),
        .jump    (jump),
        .next_pc (next_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            instr       <= 32'd0;
            retired_cnt <= '0;
        end else begin
            if (capture) begin
                instr <= imem_rdata;
            end
            if (accept) begin
                pc          <= next_pc;
                retired_cnt <= retired_cnt + CNT_W'(1);
            end
        end
    end

    assign imem_addr = pc;
    assign opcode    = {1'b0, instr[31:26]};
    assign funct     = instr[5:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; a second instance starts at 0x4000_0000 for the jump case.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        a_ack = 1'b0, a_rdy = 1'b0, a_pcsrc = 1'b0, a_jump = 1'b0;
    logic [31:0] a_rdata = 32'd0;
    logic        a_req, a_valid;
    logic [31:0] a_addr, a_instr, a_pc;
    logic [6:0]  a_opcode;
    logic [5:0]  a_funct;
    logic [3:0]  a_cnt;

    logic        b_ack = 1'b0, b_rdy = 1'b0, b_pcsrc = 1'b0, b_jump = 1'b0;
    logic [31:0] b_rdata = 32'd0;
    logic        b_req, b_valid;
    logic [31:0] b_addr, b_instr, b_pc;
    logic [6:0]  b_opcode;
    logic [5:0]  b_funct;
    logic [31:0] b_cnt;

    int checks = 0;
    int failures = 0;

    logic [31:0] beq_m2;
    logic [31:0] j_instr;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .imem_req(a_req), .imem_addr(a_addr), .imem_ack(a_ack), .imem_rdata(a_rdata),
        .instr_valid(a_valid), .instr_ready(a_rdy), .instr(a_instr),
        .opcode(a_opcode), .funct(a_funct), .pc(a_pc),
        .pcsrc(a_pcsrc), .jump(a_jump), .retired_cnt(a_cnt)
    );

    instr_fetch_unit #(.RESET_PC(32'h4000_0000), .CNT_W(32)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .imem_req(b_req), .imem_addr(b_addr), .imem_ack(b_ack), .imem_rdata(b_rdata),
        .instr_valid(b_valid), .instr_ready(b_rdy), .instr(b_instr),
        .opcode(b_opcode), .funct(b_funct), .pc(b_pc),
        .pcsrc(b_pcsrc), .jump(b_jump), .retired_cnt(b_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        beq_m2  = {OP_BEQ[5:0], 10'd0, 16'hFFFE};
        j_instr = {OP_J[5:0], 26'h000_0040};

        // reset values
        step();
        step();
        chk("rst_req", {31'd0, a_req}, 32'd0);
        chk("rst_valid", {31'd0, a_valid}, 32'd0);
        chk("rst_instr", a_instr, 32'd0);
        chk("rst_cnt", {28'd0, a_cnt}, 32'd0);
        chk("rst_addr", a_addr, 32'd0);
        rst_n = 1'b1;
        chk("idle_req", {31'd0, a_req}, 32'd0);
        step();

        // zero-wait memory, decode always ready: 2 cycles per instruction
        a_ack = 1'b1;
        a_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_rdata = 32'h0040_0020 + 32'(i);
            chk("seq_req", {31'd0, a_req}, 32'd1);
            chk("seq_addr", a_addr, 32'(4 * i));
            step();
            chk("seq_valid", {31'd0, a_valid}, 32'd1);
            chk("seq_funct", {26'd0, a_funct}, 32'h20 + 32'(i));
            chk("seq_pc", a_pc, 32'(4 * i));
        step();
        end
        chk("seq_cnt4", {28'd0, a_cnt}, 32'd4);

        // ack delayed 3 cycles at pc 0x10
        a_ack = 1'b0;
        a_rdy = 1'b0;
        a_rdata = beq_m2;
        for (int i = 0; i < 3; i++) begin
            chk("wait_req", {31'd0, a_req}, 32'd1);
            chk("wait_addr", a_addr, 32'h10);
            chk("wait_instr", a_instr, 32'h0040_0023);
            step();
        end
        chk("wait_req4", {31'd0, a_req}, 32'd1);
        a_ack = 1'b1;
        step();
        chk("ack_instr", a_instr, beq_m2);
        chk("ack_opcode", {25'd0, a_opcode}, {25'd0, OP_BEQ});
        chk("ack_valid", {31'd0, a_valid}, 32'd1);

        // stray ack in HOLD plus a 5-cycle stall; pcsrc/jump outside accept ignored
        a_rdata = 32'h1234_5678;
        a_pcsrc = 1'b1;
        a_jump  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_instr", a_instr, beq_m2);
            chk("stall_valid", {31'd0, a_valid}, 32'd1);
            chk("stall_pc", a_pc, 32'h10);
            chk("stall_req", {31'd0, a_req}, 32'd0);
        end
        a_ack  = 1'b0;
        a_jump = 1'b0;

        // taken branch: 0x14 - 8 = 0x0C
        a_rdy = 1'b1;
        step();
        a_rdy = 1'b0;
        a_pcsrc = 1'b0;
        chk("br_taken", a_addr, 32'h0C);
        chk("br_cnt", {28'd0, a_cnt}, 32'd5);

        // fetch 0x0C sequentially, then the branch word again at 0x10 not taken
        a_ack = 1'b1; a_rdata = 32'h0000_0020;
        step();
        a_ack = 1'b0; a_rdy = 1'b1;
        step();
        chk("seq_0c", a_addr, 32'h10);
        a_rdy = 1'b0; a_ack = 1'b1; a_rdata = beq_m2;
        step();
        a_ack = 1'b0; a_rdy = 1'b1;
        step();
        a_rdy = 1'b0;
        chk("br_not", a_addr, 32'h14);
        chk("br_not_cnt", {28'd0, a_cnt}, 32'd7);

        // reset mid-REQ drops imem_req at once
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_req", {31'd0, a_req}, 32'd0);
        chk("midrst_addr", a_addr, 32'd0);
        chk("midrst_cnt", {28'd0, a_cnt}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        chk("restart_req", {31'd0, a_req}, 32'd1);
        chk("restart_addr", a_addr, 32'd0);

        // branch back from 0 to 0xFFFF_FFFC, then sequential wrap to 0
        a_ack = 1'b1; a_rdata = beq_m2;
        step();
        a_ack = 1'b0; a_pcsrc = 1'b1; a_rdy = 1'b1;
        step();
        a_pcsrc = 1'b0; a_rdy = 1'b0;
        chk("to_top", a_addr, 32'hFFFF_FFFC);
        a_ack = 1'b1; a_rdata = 32'h0000_0020;
        step();
        a_ack = 1'b0; a_rdy = 1'b1;
        step();
        chk("pc_wrap", a_addr, 32'h0);
        chk("cnt2", {28'd0, a_cnt}, 32'd2);

        // retired counter wraps 15 -> 0
        a_ack = 1'b1;
        for (int i = 0; i < 13; i++) begin
            step();
            step();
        end
        chk("cnt15", {28'd0, a_cnt}, 32'd15);
        step();
        step();
        chk("cnt_wrap", {28'd0, a_cnt}, 32'd0);
        a_ack = 1'b0; a_rdy = 1'b0;

        // jump wins over pcsrc on the second instance
        chk("b_addr0", b_addr, 32'h4000_0000);
        chk("b_req", {31'd0, b_req}, 32'd1);
        b_ack = 1'b1; b_rdata = j_instr;
        step();
        b_ack = 1'b0;
        chk("b_instr", b_instr, j_instr);
        chk("b_opcode", {25'd0, b_opcode}, {25'd0, OP_J});
        b_rdy = 1'b1; b_jump = 1'b1; b_pcsrc = 1'b1;
        step();
        b_rdy = 1'b0; b_jump = 1'b0; b_pcsrc = 1'b0;
        chk("jump_addr", b_addr, 32'h4000_0100);
        chk("b_cnt", b_cnt, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
